distributed_ram_multiport: RTL and testbench
============================================

Name: distributed_ram_multiport

Overview:
Parametrised distributed RAM with one synchronous write port and READ_PORTS asynchronous read ports.
- Writes support per-byte enables.
- A built-in clear sequencer zeroes the whole array after every reset, because the LUT-RAM array itself cannot be reset.
- Next-generation replacement for the single-port 32-bit RAM used in the lab tops; sits directly behind a core or testbench driver.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDRESS_WIDTH, 8, address bits; depth = 2**ADDRESS_WIDTH.
- READ_PORTS, 2, number of independent read ports (>=1).
- BYTE_WIDTH, 8, bits per write-enable lane.

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ram_ready  output  1  high when the clear sweep is done and writes are accepted.
- ram_write_enabled  input  1  write strobe.
- ram_write_byte_enable  input  DATA_WIDTH/BYTE_WIDTH  per-lane write mask.
- ram_write_address  input  ADDRESS_WIDTH  write address.
- ram_write_data  input  DATA_WIDTH  write data.
- ram_read_address  input  READ_PORTS*ADDRESS_WIDTH  packed read addresses; port i is at slice i.
- ram_read_data  output  READ_PORTS*DATA_WIDTH  packed read data; port i is at slice i.

Behaviour:
- State machine: CLEAR, READY.
  - reset_n low: state=CLEAR, clear counter=0, ram_ready=0.
  - CLEAR: each cycle writes 0 to mem[counter], then counter+1.
  - CLEAR exits to READY on the edge that clears address DEPTH-1. CLEAR lasts exactly DEPTH cycles after reset release.
  - READY: remains until the next reset.
- Reset mid-sweep or during READY: return immediately to CLEAR, counter=0. The full sweep restarts.
- ram_ready = (state==READY), registered. Reset value 0.
- Writes while in CLEAR are ignored. No queuing, no error flag.
- Write in READY: on the rising edge with ram_write_enabled=1, lane k of mem[ram_write_address] takes ram_write_data lane k if ram_write_byte_enable[k]=1. Other lanes keep their value.
  - Byte enable all-zero: no change.
  - ram_write_enabled=0: no change regardless of byte enables.
- Read, default build: combinational. ram_read_data slice i = mem[ram_read_address slice i], zero latency.
  - In CLEAR, all read slices are forced to 0.
  - Read-during-write to the same address returns the old word until the edge; the new word is visible after the edge.
- Multiple read ports may address the same or different words simultaneously; there are no conflicts.
- The address width exactly covers the depth, so there is no out-of-range case. Counter wrap occurs only at the CLEAR exit and is unused afterwards.
- Elaboration error if DATA_WIDTH % BYTE_WIDTH != 0 or READ_PORTS < 1.

Optional Feature:
Macro: DISTRIBUTED_RAM_READ_REGISTER_EN.
- Defined:
  - Each read slice is registered, giving 1-cycle latency: data presented after edge N reflects the address sampled at edge N.
  - Write-first bypass: if the sampled read address equals the write address of an accepted write at that edge, the output uses new bytes on enabled lanes and old bytes elsewhere.
  - Output registers reset to 0 and load 0 while in CLEAR.
- Undefined: combinational read as specified above, with no bypass.

Decomposition:
- Package distributed_ram_pkg holds:
  - ram_state_t enum {RAM_CLEAR, RAM_READY};
  - default width constants;
  - function lane_count(DATA_WIDTH, BYTE_WIDTH).
- Sub-module distributed_ram_clear_sequencer owns the state machine and clear counter. It outputs clear_active, clear_address and ram_ready. The top muxes the sequencer's write path against the user write path.

Test Plan:
- Reset release, hold reads at 0xf0 and 0x00 -> ram_ready=0 for exactly 256 cycles, then 1; reads return 0x00000000 throughout and after.
- Write 0xf0 = 0x11223344 with byte enable 0xF, then read port 0 at 0xf0 and port 1 at 0xf1 -> 0x11223344 and 0x00000000.
- Byte merge: after the prior write, write 0xf0 = 0xAABBCCDD with byte enable 0x5 -> read 0x11BB33DD. Byte enable 0x0 with write enabled -> unchanged.
- Burst write 0xf0..0xf4 = 0xff00, 0xff11, 0xff22, 0xff33, 0xff44 on consecutive cycles, then read both ports across addresses -> each returns the matching value. Same address on both ports gives identical data.
- Write attempted at cycle 10 of CLEAR, then reset_n pulsed low at cycle 100 of a second sweep -> write is lost; ram_ready stays 0 for a full 256 cycles from the second release; all reads 0.
- With DISTRIBUTED_RAM_READ_REGISTER_EN: read 0xf0 while writing 0x55667788 there with byte enable 0xC -> next-cycle output is 0x55663344 (old contents 0x11223344); read of 0xf1 lags its address by one cycle.

Source files
------------

// File: rtl/distributed_ram_pkg.sv
// Shared types and defaults for the multi-port distributed RAM and its clear sequencer.
package distributed_ram_pkg;

    typedef enum logic {
        RAM_CLEAR,
        RAM_READY
    } ram_state_t;

    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam int DEFAULT_ADDRESS_WIDTH = 8;
    localparam int DEFAULT_READ_PORTS    = 2;
    localparam int DEFAULT_BYTE_WIDTH    = 8;

    function automatic int lane_count(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

endpackage

// File: rtl/distributed_ram_clear_sequencer.sv
// Post-reset sweep controller: walks every address once so the (non-resettable)
// LUT-RAM array starts at zero, then reports ready until the next reset.
module distributed_ram_clear_sequencer
    import distributed_ram_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     clear_active,
    output logic [ADDRESS_WIDTH-1:0] clear_address,
    output logic                     ram_ready
);

    ram_state_t               state_q;
    logic [ADDRESS_WIDTH-1:0] count_q;
    logic                     ready_q;

    // The counter wraps back to zero on the exit edge and is left idle in READY.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RAM_CLEAR;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                RAM_CLEAR: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == '1) begin
                        state_q <= RAM_READY;
                        ready_q <= 1'b1;
                    end
                end
                RAM_READY: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= RAM_CLEAR;
                    count_q <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_active  = (state_q == RAM_CLEAR);
    assign clear_address = count_q;
    assign ram_ready     = ready_q;

endmodule

// File: rtl/distributed_ram_multiport.sv
// Distributed RAM: one byte-masked synchronous write port, READ_PORTS read ports.
// Define DISTRIBUTED_RAM_READ_REGISTER_EN for registered reads with write-first bypass.
module distributed_ram_multiport
    import distributed_ram_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int READ_PORTS    = DEFAULT_READ_PORTS,
    parameter int BYTE_WIDTH    = DEFAULT_BYTE_WIDTH
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    output logic                                 ram_ready,
    input  logic                                 ram_write_enabled,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     ram_write_byte_enable,
    input  logic [ADDRESS_WIDTH-1:0]             ram_write_address,
    input  logic [DATA_WIDTH-1:0]                ram_write_data,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0]  ram_read_address,
    output logic [READ_PORTS*DATA_WIDTH-1:0]     ram_read_data
);

    localparam int LANES = lane_count(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    generate
        if ((DATA_WIDTH % BYTE_WIDTH) != 0 || READ_PORTS < 1) begin : g_bad_config
            $error("distributed_ram_multiport: DATA_WIDTH must be a multiple of BYTE_WIDTH and READ_PORTS >= 1");
        end
    endgenerate

    logic                     clear_active;
    logic [ADDRESS_WIDTH-1:0] clear_address;
    logic                     wr_accept;
    logic [DATA_WIDTH-1:0]    wr_mask;
    logic [DATA_WIDTH-1:0]    wr_word;
    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    distributed_ram_clear_sequencer #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_clear_sequencer (
        .clock         (clock),
        .reset_n       (reset_n),
        .clear_active  (clear_active),
        .clear_address (clear_address),
        .ram_ready     (ram_ready)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_mask
            assign wr_mask[gi*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{ram_write_byte_enable[gi]}};
        end
    endgenerate

    // Merged word for the addressed entry; shared by the array write and the read bypass.
    assign wr_accept = ram_write_enabled && !clear_active;
    assign wr_word   = (mem[ram_write_address] & ~wr_mask) | (ram_write_data & wr_mask);

    always_ff @(posedge clock) begin
        if (clear_active) begin
            mem[clear_address] <= '0;
        end else if (wr_accept) begin
            mem[ram_write_address] <= wr_word;
        end
    end

    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : g_read_port
            logic [ADDRESS_WIDTH-1:0] rd_addr;
            assign rd_addr = ram_read_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
`ifdef DISTRIBUTED_RAM_READ_REGISTER_EN
            logic [DATA_WIDTH-1:0] read_d;
            logic [DATA_WIDTH-1:0] read_q;

            always_comb begin
                read_d = mem[rd_addr];
                if (wr_accept && (rd_addr == ram_write_address)) begin
                    read_d = wr_word;
                end
                if (clear_active) begin
                    read_d = '0;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    read_q <= '0;
                end else begin
                    read_q <= read_d;
                end
            end

            assign ram_read_data[gi*DATA_WIDTH +: DATA_WIDTH] = read_q;
`else
            assign ram_read_data[gi*DATA_WIDTH +: DATA_WIDTH] = clear_active ? '0 : mem[rd_addr];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_distributed_ram_multiport.sv
// Self-checking bench for distributed_ram_multiport: vector table, hand sequences,
// and randomized traffic against a byte-level array model.
module tb_distributed_ram_multiport;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ram_ready;
    logic        we;
    logic [3:0]  be;
    logic [7:0]  wa;
    logic [31:0] wd;
    logic [7:0]  ra0, ra1;
    logic [15:0] ra;
    logic [63:0] rd;
    logic [31:0] rd0, rd1;

    logic [31:0] model [256];
    int          tests = 0;
    int          fails = 0;

    assign ra  = {ra1, ra0};
    assign rd0 = rd[31:0];
    assign rd1 = rd[63:32];

    always #5 clock = ~clock;

    distributed_ram_multiport dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .ram_ready             (ram_ready),
        .ram_write_enabled     (we),
        .ram_write_byte_enable (be),
        .ram_write_address     (wa),
        .ram_write_data        (wd),
        .ram_read_address      (ra),
        .ram_read_data         (rd)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  ra0;
        logic [7:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs [4];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        for (int k = 0; k < 4; k++)
            if (m[k]) model[a][k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] m, input logic [31:0] d);
        we = 1'b1; be = m; wa = a; wd = d;
        tick();
        we = 1'b0;
        model_write(a, m, d);
    endtask

    // Present read addresses and compare both ports after the read latency.
    task automatic read_check(input string name, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [31:0] e0, input logic [31:0] e1);
        ra0 = a0; ra1 = a1;
`ifdef DISTRIBUTED_RAM_READ_REGISTER_EN
        tick();
`else
        #1;
`endif
        check32({name, "_p0"}, rd0, e0);
        check32({name, "_p1"}, rd1, e1);
        $display("[TB] %s: rd[%02h]=%08h rd[%02h]=%08h", name, a0, rd0, a1, rd1);
    endtask

    // Runs a clear sweep from a just-released reset; optionally pokes a write at
    // cycle write_at and aborts at cycle abort_at. Returns the cycle count.
    task automatic sweep(input int write_at, input int abort_at, output int n);
        n = 0;
        ra0 = 8'hf0; ra1 = 8'h00;
        while (ram_ready !== 1'b1 && n != abort_at && n < 400) begin
            check32("clear_rd0", rd0, 32'h0);
            check32("clear_rd1", rd1, 32'h0);
            if (n == write_at) begin
                we = 1'b1; be = 4'hF; wa = 8'hf0; wd = 32'h12345678;
            end else begin
                we = 1'b0;
            end
            tick();
            n++;
        end
        we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check32("reset_ready", {31'h0, ram_ready}, 32'h0);
        tick();
        reset_n = 1'b1;
        model_clear();
    endtask

    initial begin
        int n;
        reset_n = 1'b0; we = 1'b0; be = 4'h0; wa = 8'h0; wd = 32'h0;
        ra0 = 8'hf0; ra1 = 8'h00;
        model_clear();

        vecs[0] = '{1'b1, 4'hF, 8'hf0, 32'h11223344, 8'hf0, 8'hf1, 32'h11223344, 32'h00000000};
        vecs[1] = '{1'b1, 4'h5, 8'hf0, 32'hAABBCCDD, 8'hf0, 8'hf1, 32'h11BB33DD, 32'h00000000};
        vecs[2] = '{1'b1, 4'h0, 8'hf0, 32'hFFFFFFFF, 8'hf0, 8'hf0, 32'h11BB33DD, 32'h11BB33DD};
        vecs[3] = '{1'b0, 4'hF, 8'hf1, 32'hDEADBEEF, 8'hf1, 8'hf0, 32'h00000000, 32'h11BB33DD};

        // Reset and the initial clear sweep.
        repeat (3) tick();
        check32("reset_ready", {31'h0, ram_ready}, 32'h0);
        check32("reset_rd0", rd0, 32'h0);
        reset_n = 1'b1;
        sweep(-1, -1, n);
        check32("sweep_len", n, 256);
        check32("ready_high", {31'h0, ram_ready}, 32'h1);
        read_check("post_clear", 8'hf0, 8'h00, 32'h0, 32'h0);

        for (int i = 0; i < 4; i++) begin
            we = vecs[i].we; be = vecs[i].be; wa = vecs[i].wa; wd = vecs[i].wd;
            tick();
            we = 1'b0;
            if (vecs[i].we) model_write(vecs[i].wa, vecs[i].be, vecs[i].wd);
            read_check($sformatf("vec%0d", i), vecs[i].ra0, vecs[i].ra1, vecs[i].exp0, vecs[i].exp1);
        end

        // Back-to-back burst, then cross reads including same-address on both ports.
        for (int i = 0; i < 5; i++) do_write(8'hf0 + 8'(i), 4'hF, 32'hff00 + 32'(i) * 32'h11);
        for (int i = 0; i < 5; i++)
            read_check($sformatf("burst%0d", i), 8'hf0 + 8'(i), 8'hf4 - 8'(i),
                       32'hff00 + 32'(i) * 32'h11, 32'hff00 + 32'(4 - i) * 32'h11);
        read_check("burst_same", 8'hf2, 8'hf2, 32'hff22, 32'hff22);

`ifdef DISTRIBUTED_RAM_READ_REGISTER_EN
        do_write(8'hf0, 4'hF, 32'h11223344);
        do_write(8'hf1, 4'hF, 32'h0000abcd);
        ra0 = 8'hf0; ra1 = 8'hf0;
        tick();
        we = 1'b1; be = 4'hC; wa = 8'hf0; wd = 32'h55667788; ra1 = 8'hf1;
        #1;
        check32("lag_p1", rd1, 32'h11223344);
        tick();
        we = 1'b0;
        model_write(8'hf0, 4'hC, 32'h55667788);
        check32("bypass_p0", rd0, 32'h55663344);
        check32("lag_p1_next", rd1, 32'h0000abcd);
        $display("[TB] bypass: rd0=%08h rd1=%08h", rd0, rd1);
`endif

        // Random traffic: writes and reads concentrated on the upper 16 words.
        for (int it = 0; it < 300; it++) begin
            we  = ($urandom_range(3) != 0);
            be  = 4'($urandom);
            wa  = 8'hf0 | 8'($urandom_range(15));
            wd  = $urandom;
            ra0 = ($urandom_range(2) == 0) ? wa : (8'hf0 | 8'($urandom_range(15)));
            ra1 = 8'($urandom);
`ifndef DISTRIBUTED_RAM_READ_REGISTER_EN
            #2;
            check32("rnd_old_p0", rd0, model[ra0]);
            check32("rnd_old_p1", rd1, model[ra1]);
`endif
            @(posedge clock);
            #1;
            if (we) model_write(wa, be, wd);
            check32("rnd_new_p0", rd0, model[ra0]);
            check32("rnd_new_p1", rd1, model[ra1]);
        end
        we = 1'b0;
        $display("[TB] random: 300 transactions done");

        // Reset mid-life: write during CLEAR is dropped, reset at cycle 100 restarts the sweep.
        pulse_reset();
        sweep(10, 100, n);
        check32("abort_at", n, 100);
        check32("abort_ready", {31'h0, ram_ready}, 32'h0);
        pulse_reset();
        sweep(-1, -1, n);
        check32("resweep_len", n, 256);
        check32("resweep_ready", {31'h0, ram_ready}, 32'h1);
        for (int i = 0; i < 5; i++)
            read_check($sformatf("cleared%0d", i), 8'hf0 + 8'(i), 8'hf4 - 8'(i), 32'h0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
